router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_pkg.sv | 53 +++++
 rtl/router_fsm_if.sv | 40 ++++
 rtl/router_fsm.sv | 92 +++++++++
 tb/tb_router_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the packet-router control FSM.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
    localparam logic [2:0] ST_LOAD_PARITY        = 3'd3;
    localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd7;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = ST_DECODE_ADDRESS,
        LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
        LOAD_DATA          = ST_LOAD_DATA,
        LOAD_PARITY        = ST_LOAD_PARITY,
        FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
        LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR
    } state_e;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } strobes_t;

    // Moore decode of a state into its output strobes.
    function automatic strobes_t decode_state(state_e s);
        strobes_t o;
        o = '0;
        o.detect_add    = (s == DECODE_ADDRESS);
        o.lfd_state     = (s == LOAD_FIRST_DATA);
        o.ld_state      = (s == LOAD_DATA);
        o.laf_state     = (s == LOAD_AFTER_FULL);
        o.full_state    = (s == FIFO_FULL_STATE);
        o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
        o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        o.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
        return o;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control/status bundle between the router FSM and its FIFOs/register block.
interface router_fsm_if;

    logic                            pkt_valid;
    logic [router_pkg::ADDR_W-1:0]   data_in;
    logic                            fifo_full;
    logic                            fifo_empty_0;
    logic                            fifo_empty_1;
    logic                            fifo_empty_2;
    logic                            soft_rst_0;
    logic                            soft_rst_1;
    logic                            soft_rst_2;
    logic                            parity_done;
    logic                            low_pkt_valid;

    logic                            detect_add;
    logic                            lfd_state;
    logic                            ld_state;
    logic                            laf_state;
    logic                            full_state;
    logic                            rst_int_reg;
    logic                            write_enb_reg;
    logic                            busy;
    logic [router_pkg::ADDR_W-1:0]   addr_q;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, addr_q
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, addr_q
    );

endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loading, stalls on a full FIFO and waits for an occupied FIFO to drain.
module router_fsm
    import router_pkg::*;
(
    input logic       clk,
    input logic       rst,
    router_fsm_if.slave bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    strobes_t            out_q;
    logic                empty_hdr;
    logic                empty_sel;
    logic                soft_sel;

    function automatic logic pick3(logic [ADDR_W-1:0] a, logic b0, logic b1, logic b2);
        logic r;
        case (a)
            2'd0:    r = b0;
            2'd1:    r = b1;
            2'd2:    r = b2;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        empty_hdr = pick3(bus.data_in, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
        empty_sel = pick3(addr_q, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
        soft_sel  = pick3(addr_q, bus.soft_rst_0, bus.soft_rst_1, bus.soft_rst_2);

        addr_d = addr_q;
        if (state_q == DECODE_ADDRESS && bus.pkt_valid && bus.data_in != ADDR_INVALID)
            addr_d = bus.data_in;

        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS:
                if (bus.pkt_valid && bus.data_in != ADDR_INVALID)
                    state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                state_d = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            LOAD_PARITY:
                state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE:
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            WAIT_TILL_EMPTY:
                if (empty_sel) state_d = LOAD_FIRST_DATA;
            default:
                state_d = DECODE_ADDRESS;
        endcase

        // Soft reset only counts for the FIFO this packet is routed to.
        if (soft_sel)
            state_d = DECODE_ADDRESS;
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
            out_q   <= decode_state(DECODE_ADDRESS);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= decode_state(state_d);
        end
    end

    assign bus.detect_add    = out_q.detect_add;
    assign bus.lfd_state     = out_q.lfd_state;
    assign bus.ld_state      = out_q.ld_state;
    assign bus.laf_state     = out_q.laf_state;
    assign bus.full_state    = out_q.full_state;
    assign bus.rst_int_reg   = out_q.rst_int_reg;
    assign bus.write_enb_reg = out_q.write_enb_reg;
    assign bus.busy          = out_q.busy;
    assign bus.addr_q        = addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: a behavioural model predicts each cycle's
// strobes and address, directed scenarios add spot checks, then random traffic.
module tb_router_fsm;

    localparam int M_DA = 0, M_LFD = 1, M_LD = 2, M_LP = 3;
    localparam int M_FF = 4, M_LAF = 5, M_WTE = 6, M_CPE = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_fsm_if bus ();
    router_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    int         ms;
    logic [1:0] ma;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
    function automatic logic [7:0] exp_strobes(int s);
        logic [7:0] t [8];
        t[M_DA]  = 8'b1000_0000;
        t[M_LFD] = 8'b0100_0001;
        t[M_LD]  = 8'b0010_0010;
        t[M_LP]  = 8'b0000_0011;
        t[M_FF]  = 8'b0000_1001;
        t[M_LAF] = 8'b0001_0011;
        t[M_WTE] = 8'b0000_0001;
        t[M_CPE] = 8'b0000_0101;
        return t[s];
    endfunction

    task automatic step(input string tag);
        int         ns;
        logic [1:0] na;
        logic [2:0] emp, sft;
        logic [9:0] e, got;
        emp = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
        sft = {bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0};
        ns = ms;
        na = ma;
        if (ms == M_DA && bus.pkt_valid && bus.data_in != 2'd3) na = bus.data_in;
        case (ms)
            M_DA:  if (bus.pkt_valid && bus.data_in != 2'd3) ns = emp[bus.data_in] ? M_LFD : M_WTE;
            M_LFD: ns = M_LD;
            M_LD:  ns = bus.fifo_full ? M_FF : (!bus.pkt_valid ? M_LP : M_LD);
            M_LP:  ns = M_CPE;
            M_CPE: ns = bus.fifo_full ? M_FF : M_DA;
            M_FF:  ns = bus.fifo_full ? M_FF : M_LAF;
            M_LAF: ns = bus.parity_done ? M_DA : (bus.low_pkt_valid ? M_LP : M_LD);
            M_WTE: ns = emp[ma] ? M_LFD : M_WTE;
            default: ns = M_DA;
        endcase
        if (sft[ma]) ns = M_DA;
        if (rst) begin
            ns = M_DA;
            na = 2'd0;
        end
        ms = ns;
        ma = na;
        exp_q.push_back({exp_strobes(ns), na});
        @(posedge clk);
        #1;
        got = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
               bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.addr_q};
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {22'd0, got}, {22'd0, e});
        end
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_rst_0    = 1'b0;
        bus.soft_rst_1    = 1'b0;
        bus.soft_rst_2    = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    initial begin
        ms = M_DA;
        ma = 2'd0;
        idle_inputs();
        rst = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step("reset0");
        step("reset1");
        check("rst_detect_add", {31'd0, bus.detect_add}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_addr", {30'd0, bus.addr_q}, 32'd0);

        // Header to FIFO 1, payload, then parity.
        rst = 1'b0;
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        step("hdr1");
        check("lfd_state", {31'd0, bus.lfd_state}, 32'd1);
        check("lfd_busy", {31'd0, bus.busy}, 32'd1);
        check("lfd_addr", {30'd0, bus.addr_q}, 32'd1);
        step("ld1");
        check("ld_state", {31'd0, bus.ld_state}, 32'd1);
        check("ld_busy", {31'd0, bus.busy}, 32'd0);
        bus.pkt_valid = 1'b0;
        step("lp1");
        check("lp_wen", {31'd0, bus.write_enb_reg}, 32'd1);
        check("lp_busy", {31'd0, bus.busy}, 32'd1);
        step("cpe1");
        check("cpe_rst_int", {31'd0, bus.rst_int_reg}, 32'd1);
        step("da1");
        check("da_after_parity", {31'd0, bus.detect_add}, 32'd1);

        // Full stall of three cycles, resumed with low_pkt_valid.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd0;
        step("hdr0");
        step("ld0");
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("full");
            check("full_state", {31'd0, bus.full_state}, 32'd1);
            check("full_wen", {31'd0, bus.write_enb_reg}, 32'd0);
        end
        bus.fifo_full     = 1'b0;
        bus.low_pkt_valid = 1'b1;
        step("laf");
        check("laf_state", {31'd0, bus.laf_state}, 32'd1);
        step("laf_to_lp");
        check("laf_lp_wen", {31'd0, bus.write_enb_reg}, 32'd1);
        bus.low_pkt_valid = 1'b0;
        bus.pkt_valid     = 1'b0;
        step("cpe0");
        step("da0");

        // Busy destination FIFO 2.
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 2'd2;
        bus.fifo_empty_2 = 1'b0;
        step("wte_a");
        check("wte_strobes", {26'd0, bus.detect_add, bus.lfd_state, bus.ld_state,
              bus.laf_state, bus.full_state, bus.rst_int_reg}, 32'd0);
        check("wte_busy", {31'd0, bus.busy}, 32'd1);
        step("wte_b");
        bus.fifo_empty_2 = 1'b1;
        step("wte_lfd");
        check("wte_to_lfd", {31'd0, bus.lfd_state}, 32'd1);
        bus.pkt_valid = 1'b0;
        step("ld2");
        step("lp2");
        step("cpe2");
        step("da2");

        // Invalid address leaves the latch untouched.
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        step("bad_addr");
        check("bad_addr_hold", {30'd0, bus.addr_q}, 32'd2);
        check("bad_addr_detect", {31'd0, bus.detect_add}, 32'd1);

        // Soft resets: foreign ignored, own aborts; hard reset while stalled.
        bus.data_in = 2'd0;
        step("hdr0b");
        step("ld0b");
        bus.soft_rst_1 = 1'b1;
        step("soft1");
        check("soft1_ignored", {31'd0, bus.ld_state}, 32'd1);
        bus.soft_rst_1 = 1'b0;
        bus.soft_rst_0 = 1'b1;
        step("soft0");
        check("soft0_abort", {31'd0, bus.detect_add}, 32'd1);
        bus.soft_rst_0 = 1'b0;
        step("hdr0c");
        step("ld0c");
        bus.fifo_full = 1'b1;
        step("ff0c");
        step("ff0c2");
        bus.data_in = 2'd1;
        rst = 1'b1;
        step("rst_in_full");
        check("rst_full_detect", {31'd0, bus.detect_add}, 32'd1);
        check("rst_full_addr", {30'd0, bus.addr_q}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        step("idle");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst               = ($urandom_range(99) < 2);
            bus.pkt_valid     = ($urandom_range(99) < 70);
            bus.data_in       = 2'($urandom_range(3));
            bus.fifo_full     = ($urandom_range(99) < 25);
            bus.fifo_empty_0  = ($urandom_range(99) < 70);
            bus.fifo_empty_1  = ($urandom_range(99) < 70);
            bus.fifo_empty_2  = ($urandom_range(99) < 70);
            bus.soft_rst_0    = ($urandom_range(99) < 4);
            bus.soft_rst_1    = ($urandom_range(99) < 4);
            bus.soft_rst_2    = ($urandom_range(99) < 4);
            bus.parity_done   = ($urandom_range(99) < 30);
            bus.low_pkt_valid = ($urandom_range(99) < 30);
            step("random");
        end

        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
